// File: rtl/bf16mul_arbiter.sv
// bf16mul_arbiter: round-robin arbiter sharing one combinational bf16 x bf16 -> fp32
// multiplier among NREQ valid/ready requesters, with a 2-stage operand/result pipeline
// and full output backpressure.
// Optional: define BF16MUL_ARB_STATS_EN to add stat_issued / stat_stall counters.

// Combinational bf16 x bf16 -> fp32 multiply. The 8x8 significand product fits the
// fp32 fraction exactly, so no rounding is needed. Subnormal inputs and underflowed
// results flush to signed zero; overflow saturates to signed infinity; any NaN or
// Inf x 0 yields the canonical quiet NaN.
module bfloat16mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic        sgn;
    logic [7:0]  ea, eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [15:0] prod;
    logic [9:0]  esum;
    logic [22:0] frac;

    // Classify operands and form the normalised product.
    always_comb begin
        sgn    = a[15] ^ b[15];
        ea     = a[14:7];
        eb     = b[14:7];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (a[6:0] == 7'd0);
        b_inf  = (eb == 8'hFF) && (b[6:0] == 7'd0);
        a_nan  = (ea == 8'hFF) && (a[6:0] != 7'd0);
        b_nan  = (eb == 8'hFF) && (b[6:0] != 7'd0);
        prod   = {1'b1, a[6:0]} * {1'b1, b[6:0]};
        // Biased sum still carries one extra bias; subtract 127 only after range checks.
        esum   = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[15]};
        frac   = prod[15] ? {prod[14:0], 8'd0} : {prod[13:0], 9'd0};
        p      = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            p = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            p = {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero || (esum <= 10'd127))
            p = {sgn, 31'd0};
        else if (esum >= 10'd382)
            p = {sgn, 8'hFF, 23'd0};
        else
            p = {sgn, 8'(esum - 10'd127), frac};
    end
endmodule

module bf16mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_p,
    output logic [IDW-1:0]       out_id
`ifdef BF16MUL_ARB_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);
    localparam int unsigned N = NREQ;

    logic            s1_v_q, s1_v_d;
    logic [15:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [31:0]     s2_p_q, s2_p_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [IDW-1:0]  rr_q, rr_d;

    logic            adv1, adv2;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id, idx;
    logic [31:0]     prod;

    bfloat16mul u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (prod)
    );

    assign adv2 = !s2_v_q || out_ready;
    assign adv1 = !s1_v_q || adv2;

    // Cyclic priority scan starting at the round-robin pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(rr_q) + k) % N);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    // Ready is held low during reset so nothing is accepted in the reset cycle.
    always_comb begin
        req_ready = '0;
        if (!rst && gnt_any && adv1)
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
    end

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_id_d = s1_id_q;
        s2_v_d  = s2_v_q;
        s2_p_d  = s2_p_q;
        s2_id_d = s2_id_q;
        rr_d    = rr_q;
        if (adv2) begin
            s2_v_d  = s1_v_q;
            s2_p_d  = prod;
            s2_id_d = s1_id_q;
        end
        if (adv1) begin
            s1_v_d = gnt_any;
            if (gnt_any) begin
                s1_a_d  = req_a[16*gnt_id +: 16];
                s1_b_d  = req_b[16*gnt_id +: 16];
                s1_id_d = gnt_id;
                rr_d    = IDW'((32'(gnt_id) + 1) % N);
            end
        end
    end

    // Pipeline and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_p_q  <= '0;
            s2_id_q <= '0;
            rr_q    <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_p_q  <= s2_p_d;
            s2_id_q <= s2_id_d;
            rr_q    <= rr_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_p     = s2_p_q;
    assign out_id    = s2_id_q;

`ifdef BF16MUL_ARB_STATS_EN
    logic [31:0] issued_q, stall_q;

    // Count accepted requests and cycles where requests wait without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (|(req_valid & req_ready))
                issued_q <= issued_q + 32'd1;
            if ((|req_valid) && !(|req_ready))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_bf16mul_arbiter.sv
// Directed self-checking bench for bf16mul_arbiter (NREQ = 4).
module tb_bf16mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic        out_valid, out_ready;
    logic [31:0] out_p;
    logic [1:0]  out_id;
`ifdef BF16MUL_ARB_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bf16mul_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_id    (out_id)
`ifdef BF16MUL_ARB_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    typedef struct {
        int          lane;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [15:0] a, input logic [15:0] b);
        req_a[16*l +: 16] = a;
        req_b[16*l +: 16] = b;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] rr_exp[4];
        logic [3:0]  acc;
        int          n;
        int          ids[$];
        logic [31:0] ps[$];

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b1;

        vecs[0] = '{0, 16'h3F80, 16'h4000, 32'h4000_0000};
        vecs[1] = '{2, 16'hC000, 16'h4040, 32'hC0C0_0000};
        vecs[2] = '{1, 16'h7F80, 16'h0000, 32'h7FC0_0000};
        vecs[3] = '{1, 16'h3FC0, 16'h3FC0, 32'h4010_0000};
        vecs[4] = '{3, 16'h0000, 16'h3F80, 32'h0000_0000};
        vecs[5] = '{0, 16'hBF80, 16'hBF80, 32'h3F80_0000};
        vecs[6] = '{3, 16'h7F80, 16'h4000, 32'h7F80_0000};
        vecs[7] = '{2, 16'h7FC1, 16'h3F80, 32'h7FC0_0000};
        vecs[8] = '{1, 16'h7F00, 16'h7F00, 32'h7F80_0000};
        vecs[9] = '{0, 16'h8080, 16'h0080, 32'h8000_0000};

        // Reset state
        tick;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        do_reset;
        chk("reset_out_p", out_p, 32'h0);
        chk("reset_out_id", 32'(out_id), 32'h0);

        // Single product: exact latency
        out_ready = 1'b1;
        set_lane(0, 16'h3F80, 16'h4000);
        req_valid = 4'b0001;
        #1;
        chk("single_ready_c0", 32'(req_ready), 32'h1);
        tick;
        req_valid = '0;
        #1;
        chk("single_valid_c1", 32'(out_valid), 32'h0);
        tick;
        chk("single_valid_c2", 32'(out_valid), 32'h1);
        chk("single_p", out_p, 32'h4000_0000);
        chk("single_id", 32'(out_id), 32'h0);
        tick;
        chk("single_valid_c3", 32'(out_valid), 32'h0);

        // Table-driven products
        for (int i = 0; i < 10; i++) begin
            set_lane(vecs[i].lane, vecs[i].a, vecs[i].b);
            req_valid = 4'(1) << vecs[i].lane;
            #1;
            n = 0;
            while (!req_ready[vecs[i].lane] && n < 20) begin tick; n++; end
            chk("vec_accept_timeout", 32'(n < 20), 32'h1);
            tick;
            req_valid = '0;
            #1;
            n = 0;
            while (!out_valid && n < 20) begin tick; n++; end
            chk("vec_out_timeout", 32'(n < 20), 32'h1);
            chk($sformatf("vec%0d_p", i), out_p, vecs[i].p);
            chk($sformatf("vec%0d_id", i), 32'(out_id), 32'(vecs[i].lane));
            tick;
        end

        // Round-robin fairness, back-to-back outputs
        do_reset;
        out_ready = 1'b1;
        set_lane(0, 16'h3F80, 16'h3F80); rr_exp[0] = 32'h3F80_0000;
        set_lane(1, 16'h3F80, 16'h4000); rr_exp[1] = 32'h4000_0000;
        set_lane(2, 16'hC000, 16'h4040); rr_exp[2] = 32'hC0C0_0000;
        set_lane(3, 16'h4000, 16'h4000); rr_exp[3] = 32'h4080_0000;
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(4'(1) << (k % 4)));
            if (k >= 2) begin
                chk($sformatf("rr_valid%0d", k), 32'(out_valid), 32'h1);
                chk($sformatf("rr_id%0d", k), 32'(out_id), 32'((k - 2) % 4));
                chk($sformatf("rr_p%0d", k), out_p, rr_exp[(k - 2) % 4]);
            end
            tick;
        end
        req_valid = '0;
        tick; tick; tick;

        // Backpressure: out_ready low for 5 cycles, lanes 1 and 3 requesting
        do_reset;
        out_ready = 1'b0;
        set_lane(1, 16'h3F80, 16'h4000);
        set_lane(3, 16'h4000, 16'h4000);
        req_valid = 4'b1010;
        #1;
        ids.delete();
        for (int c = 0; c < 5; c++) begin
            acc = req_valid & req_ready;
            if (acc == 4'b0010) ids.push_back(1);
            if (acc == 4'b1000) ids.push_back(3);
            chk($sformatf("bp_ready_c%0d", c), 32'(req_ready),
                (c == 0) ? 32'h2 : ((c == 1) ? 32'h8 : 32'h0));
            if (c >= 2) begin
                chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'h1);
                chk($sformatf("bp_id_c%0d", c), 32'(out_id), 32'h1);
                chk($sformatf("bp_p_c%0d", c), out_p, 32'h4000_0000);
            end
            tick;
            req_valid = req_valid & ~acc;
            #1;
        end
        chk("bp_accept_count", 32'(ids.size()), 32'h2);
        if (ids.size() == 2) begin
            chk("bp_accept0", 32'(ids[0]), 32'h1);
            chk("bp_accept1", 32'(ids[1]), 32'h3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_drain0_valid", 32'(out_valid), 32'h1);
        chk("bp_drain0_id", 32'(out_id), 32'h1);
        tick;
        chk("bp_drain1_valid", 32'(out_valid), 32'h1);
        chk("bp_drain1_id", 32'(out_id), 32'h3);
        chk("bp_drain1_p", out_p, 32'h4080_0000);
        tick;
        chk("bp_drain2_valid", 32'(out_valid), 32'h0);

        // Reset mid-flight with both stages full
        do_reset;
        out_ready = 1'b0;
        set_lane(0, 16'h3F80, 16'h3F80);
        set_lane(1, 16'h3F80, 16'h3F80);
        req_valid = 4'b0011;
        #1;
        for (int c = 0; c < 2; c++) begin
            acc = req_valid & req_ready;
            tick;
            req_valid = req_valid & ~acc;
            #1;
        end
        chk("mid_full_ready", 32'(req_ready), 32'h0);
        chk("mid_full_valid", 32'(out_valid), 32'h1);
        set_lane(2, 16'h4040, 16'h4000);
        set_lane(3, 16'h3F80, 16'hC000);
        req_valid = 4'b1100;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_post_valid", 32'(out_valid), 32'h0);
        chk("mid_first_grant", 32'(req_ready), 32'h4);
        ids.delete();
        ps.delete();
        for (int c = 0; c < 6; c++) begin
            acc = req_valid & req_ready;
            if (out_valid) begin ids.push_back(int'(out_id)); ps.push_back(out_p); end
            tick;
            req_valid = req_valid & ~acc;
            #1;
        end
        chk("mid_out_count", 32'(ids.size()), 32'h2);
        if (ids.size() == 2) begin
            chk("mid_out0_id", 32'(ids[0]), 32'h2);
            chk("mid_out0_p", ps[0], 32'h40C0_0000);
            chk("mid_out1_id", 32'(ids[1]), 32'h3);
            chk("mid_out1_p", ps[1], 32'hC000_0000);
        end

`ifdef BF16MUL_ARB_STATS_EN
        // Statistics: 2 accepts + 3 stalls under backpressure, then 8 flowing accepts
        do_reset;
        chk("stat_issued_reset", stat_issued, 32'd0);
        chk("stat_stall_reset", stat_stall, 32'd0);
        set_lane(0, 16'h3F80, 16'h3F80);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        for (int c = 0; c < 5; c++) tick;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) tick;
        req_valid = '0;
        #1;
        chk("stat_issued", stat_issued, 32'd10);
        chk("stat_stall", stat_stall, 32'd3);
        do_reset;
        chk("stat_issued_clr", stat_issued, 32'd0);
        chk("stat_stall_clr", stat_stall, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
